// File: rtl/cskip_adder_pipe.sv
// cskip_adder_pipe: pipelined carry-skip adder, SUM = A + B + cin (WIDTH+1 bits).
// The operands are cut into STAGES slices of WIDTH/STAGES bits, one slice per
// stage. Each slice is a chain of BLOCK-bit ripple blocks with a skip mux.
// The whole pipe advances together under a valid/ready handshake.
// Optional feature: define CSKIP_OVF_EN to add the registered signed-overflow
// output ovf. It has the same timing as SUM.
module cskip_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   SUM
`ifdef CSKIP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SL = WIDTH / STAGES;
  localparam int NB = SL / BLOCK;

  if (STAGES < 1 || STAGES > 8 || BLOCK < 1 || (WIDTH % BLOCK) != 0 ||
      ((WIDTH / BLOCK) % STAGES) != 0) begin : g_cfg_check
    $error("cskip_adder_pipe: need WIDTH %% BLOCK == 0, (WIDTH/BLOCK) %% STAGES == 0, STAGES in 1..8");
  end

  // One slice: NB ripple blocks. A block whose bits all propagate passes its
  // carry-in straight through. Returns {carry_out, sum}.
  function automatic logic [SL:0] cskip_slice(input logic [SL-1:0] a,
                                              input logic [SL-1:0] b,
                                              input logic          ci);
    logic [SL-1:0] s;
    logic          c_blk;
    logic          c_rip;
    logic          p_all;
    s     = '0;
    c_blk = ci;
    for (int k = 0; k < NB; k++) begin
      c_rip = c_blk;
      p_all = 1'b1;
      for (int j = k * BLOCK; j < (k + 1) * BLOCK; j++) begin
        s[j]  = a[j] ^ b[j] ^ c_rip;
        c_rip = (a[j] & b[j]) | (c_rip & (a[j] ^ b[j]));
        p_all = p_all & (a[j] ^ b[j]);
      end
      c_blk = p_all ? c_blk : c_rip;
    end
    return {c_blk, s};
  endfunction

`ifdef CSKIP_OVF_EN
  // Two's-complement overflow: the operands share a sign and the result's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  logic                         adv;
  logic [STAGES-1:0]            vld_p;
  logic [STAGES-1:0]            cy_p;
  logic [STAGES-1:0][WIDTH-1:0] sum_p;
  logic [STAGES-1:0][WIDTH-1:0] a_p;
  logic [STAGES-1:0][WIDTH-1:0] b_p;
  logic                         unused_ops;

  assign out_valid = vld_p[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && rst_n;
  assign SUM       = {cy_p[STAGES-1], sum_p[STAGES-1]};

  // Operand bits below the current slice are carried along but not read again.
  assign unused_ops = ^{a_p, b_p};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             vld_i;
    logic             cy_i;
    logic [WIDTH-1:0] sum_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [SL:0]      slc;
    logic [WIDTH-1:0] sum_nx;
    logic             ld;
    logic             vld_q;
    logic             cy_q;
    logic [WIDTH-1:0] sum_q;

    // ---- stage s input boundary: ports for stage 0, previous stage otherwise
    if (s == 0) begin : g_src_port
      assign vld_i = in_valid;
      assign cy_i  = cin;
      assign sum_i = '0;
      assign a_i   = A;
      assign b_i   = B;
    end else begin : g_src_prev
      assign vld_i = vld_p[s-1];
      assign cy_i  = cy_p[s-1];
      assign sum_i = sum_p[s-1];
      assign a_i   = a_p[s-1];
      assign b_i   = b_p[s-1];
    end

    assign slc = cskip_slice(a_i[s*SL +: SL], b_i[s*SL +: SL], cy_i);
    assign ld  = adv && vld_i;

    // Merge this stage's slice into the partial sum.
    always_comb begin
      sum_nx             = sum_i;
      sum_nx[s*SL +: SL] = slc[SL-1:0];
    end

    // Stage valid bit: cleared by reset and moves only when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_q <= 1'b0;
      else if (adv) vld_q <= vld_i;
    end

    // ---- stage s output boundary
    if (s == STAGES - 1) begin : g_last
      // Output stage: SUM is cleared by reset. It loads only for a live
      // transaction, so it holds the last result between transactions.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= '0;
          cy_q  <= 1'b0;
        end else if (ld) begin
          sum_q <= sum_nx;
          cy_q  <= slc[SL];
        end
      end
      assign a_p[s] = '0;
      assign b_p[s] = '0;
`ifdef CSKIP_OVF_EN
      // The overflow flag is registered together with SUM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ovf <= 1'b0;
        else if (ld) ovf <= signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sum_nx[WIDTH-1]);
      end
`endif
    end else begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      // Intermediate data registers: partial sum, slice carry and operands still to add.
      always_ff @(posedge clk) begin
        if (ld) begin
          sum_q <= sum_nx;
          cy_q  <= slc[SL];
          a_q   <= a_i;
          b_q   <= b_i;
        end
      end
      assign a_p[s] = a_q;
      assign b_p[s] = b_q;
    end

    assign vld_p[s] = vld_q;
    assign cy_p[s]  = cy_q;
    assign sum_p[s] = sum_q;
  end

endmodule

// File: doc/cskip_adder_pipe.md
CSKIP_ADDER_PIPE -- requirements
Module: cskip_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter BLOCK, default 4: carry-skip block width in bits.
REQ-003 SHALL have parameter STAGES, default 2: number of pipeline register stages, 1..8.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operands presented.
REQ-007 SHALL have port in_ready, output, 1: operands accepted this cycle when in_valid is high.
REQ-008 SHALL have port A, input, WIDTH: addend.
REQ-009 SHALL have port B, input, WIDTH: addend.
REQ-010 SHALL have port cin, input, 1: carry-in.
REQ-011 SHALL have port out_valid, output, 1: SUM holds a result.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts SUM.
REQ-013 SHALL have port SUM, output, WIDTH+1: result; MSB is carry-out.
REQ-014 SHALL have port ovf, output, 1: signed overflow; present only under CSKIP_OVF_EN.

Function
REQ-015 SHALL elaborate only if WIDTH is a multiple of BLOCK, and WIDTH/BLOCK is a multiple of STAGES; otherwise elaboration fails.
- Design note: the default configuration (32/4/2) satisfies this.
REQ-016 SHALL split the operands into STAGES slices of WIDTH/STAGES bits, processed one slice per stage.
- Each slice is built from ripple blocks of BLOCK bits.
- Each block has a skip path: block carry-out = (all bits propagate) ? block carry-in : ripple carry-out.
REQ-017 SHALL register at each stage:
- the slice sum bits computed so far;
- the slice carry-out;
- the not-yet-added operand bits;
- a valid bit.
REQ-018 SHALL produce SUM = A + B + cin, modulo 2^(WIDTH+1), for every accepted transaction.
REQ-019 SHALL deliver each result exactly STAGES cycles after acceptance when out_ready is held high.
REQ-020 SHALL advance all stages together only when adv = (!out_valid || out_ready).
REQ-021 SHALL drive in_ready = adv, combinationally.
REQ-022 SHALL accept a transaction only on a cycle where in_valid && in_ready.
- On an advancing cycle with in_valid low, a bubble (valid=0) enters stage 1.
REQ-023 SHALL hold every stage's contents, SUM and out_valid stable while out_valid && !out_ready.
- No data loss, no duplication.
REQ-024 SHALL allow accept and retire in the same cycle (out_valid && out_ready && in_valid) with no bubble inserted.
- Sustained throughput: one result per cycle.
REQ-025 SHALL preserve acceptance order at the output.
REQ-026 SHALL produce correct results for the boundary case where carry propagates across all blocks and stages.
- Example: A = all-ones, B = 0, cin = 1.
REQ-027 SHALL ignore A, B and cin on cycles where no transaction is accepted.

Reset
REQ-028 SHALL, on assertion of rst_n low, immediately clear all stage valid bits, out_valid, SUM and ovf to 0, regardless of clk.
REQ-029 SHALL discard any in-flight transactions when reset is asserted mid-operation; they are never output.
REQ-030 SHALL hold in_ready low while rst_n is low.
REQ-031 SHALL accept new transactions from the first rising edge of clk after rst_n deasserts.

Configuration
REQ-032 SHALL, when macro CSKIP_OVF_EN is defined, provide output ovf.
- ovf = (A[MSB] == B[MSB]) && (sum[WIDTH-1] != A[MSB]).
- ovf is pipelined alongside SUM with identical timing and stall behaviour.
REQ-033 SHALL, when CSKIP_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover the basic result and latency case:
- Stimulus: A=0x0000_0005, B=0x0000_0003, cin=0, out_ready=1.
- Response: SUM=0x0_0000_0008 with out_valid high exactly 2 cycles after acceptance.
REQ-035 SHALL cover full carry propagation:
- Stimulus: A=0xFFFF_FFFF, B=0x0000_0000, cin=1.
- Response: SUM=0x1_0000_0000.
REQ-036 SHALL cover backpressure:
- Stimulus: stream 0+1, 0+2, 0+3, 0+4 back-to-back; hold out_ready low for 3 cycles after the first result.
- Response: in_ready low during the stall; SUM=1 held stable; then results 1, 2, 3, 4 in order with none lost.
REQ-037 SHALL cover reset mid-operation:
- Stimulus: two transactions in flight; pulse rst_n low between clock edges.
- Response: out_valid=0 and SUM=0 immediately; neither transaction appears afterwards.
REQ-038 SHALL cover signed overflow (CSKIP_OVF_EN defined):
- Stimulus: A=0x7FFF_FFFF, B=0x0000_0001.
- Response: SUM=0x0_8000_0000, ovf=1.
- Also: A=0xFFFF_FFFF, B=0x0000_0001 gives ovf=0.
REQ-039 SHALL cover an alternate configuration:
- Stimulus: WIDTH=16, BLOCK=2, STAGES=4, with 1000 random operands and random out_ready.
- Response: every result equals A+B+cin in order, each with latency 4 cycles when unstalled.
